tiny_axi_mux3: RTL

TINY_AXI_MUX3 -- requirements
Module: tiny_axi_mux3

---
 rtl/tiny_axi_pkg.sv | 28 ++
 rtl/bus_watchdog.sv | 34 +++
 rtl/tiny_axi_mux3.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/tiny_axi_pkg.sv
// Shared types for the three-master command/response mux:
// FSM encoding, beat-length width and watchdog counter width.
package tiny_axi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2,
        FIN  = 2'd3
    } state_e;

    localparam int BLW = 4;
    localparam int TCW = 8;

    function automatic logic onehot3(input logic [2:0] s);
        return (s == 3'b001) || (s == 3'b010) || (s == 3'b100);
    endfunction

    function automatic logic [1:0] sel_idx(input logic [2:0] s);
        if (s[2])
            return 2'd2;
        else if (s[1])
            return 2'd1;
        else
            return 2'd0;
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Counts idle response cycles; expired_o fires in the cycle
// that would bring the count up to TMO.
module bus_watchdog
    import tiny_axi_pkg::*;
#(
    parameter int TMO = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [TCW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + 1'b1;
    end

    assign expired_o = en_i && (cnt_q == TCW'(TMO - 1));

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/tiny_axi_mux3.sv
// Three-master to one-slave command mux with per-transaction
// ownership, multi-beat reads and a response timeout.
module tiny_axi_mux3
    import tiny_axi_pkg::*;
#(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int TMO = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        sel,
    output logic [2:0]        finish,
    input  logic [2:0]        m_avalid,
    input  logic [2:0]        m_awe,
    input  logic [3*AW-1:0]   m_aaddr,
    input  logic [3*DW-1:0]   m_wdata,
    input  logic [3*BLW-1:0]  m_alen,
    output logic [2:0]        m_aready,
    output logic [2:0]        m_rvalid,
    output logic [DW-1:0]     m_rdata,
    output logic              m_rerr,
    output logic              s_avalid,
    input  logic              s_aready,
    output logic              s_awe,
    output logic [AW-1:0]     s_aaddr,
    output logic [DW-1:0]     s_wdata,
    output logic [BLW-1:0]    s_alen,
    input  logic              s_rvalid,
    input  logic [DW-1:0]     s_rdata
);

    state_e         state_q, state_d;
    logic [1:0]     own_q, own_d;
    logic [BLW-1:0] beat_q, beat_d;

    logic           ow_avalid, ow_we;
    logic [AW-1:0]  ow_addr;
    logic [DW-1:0]  ow_wdata;
    logic [BLW-1:0] ow_alen;
    logic [2:0]     own_bit;
    logic           wd_clr, wd_en, tmo_exp;

    assign ow_avalid = m_avalid[own_q];
    assign ow_we     = m_awe[own_q];
    assign ow_addr   = m_aaddr[int'(own_q)*AW +: AW];
    assign ow_wdata  = m_wdata[int'(own_q)*DW +: DW];
    assign ow_alen   = m_alen[int'(own_q)*BLW +: BLW];
    assign own_bit   = 3'b001 << own_q;

    // Any beat restarts the idle count; outside RESP it is held at zero.
    assign wd_en  = (state_q == RESP) && !s_rvalid;
    assign wd_clr = (state_q != RESP) || s_rvalid;

    bus_watchdog #(
        .TMO(TMO)
    ) u_wd (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expired_o(tmo_exp)
    );

    always_comb begin
        state_d  = state_q;
        own_d    = own_q;
        beat_d   = beat_q;
        finish   = '0;
        m_aready = '0;
        m_rvalid = '0;
        m_rdata  = '0;
        m_rerr   = 1'b0;
        s_avalid = 1'b0;
        s_awe    = 1'b0;
        s_aaddr  = '0;
        s_wdata  = '0;
        s_alen   = '0;
        unique case (state_q)
            IDLE: begin
                if (onehot3(sel)) begin
                    state_d = ADDR;
                    own_d   = sel_idx(sel);
                end
            end
            ADDR: begin
                s_avalid = ow_avalid;
                s_awe    = ow_we;
                s_aaddr  = ow_addr;
                s_wdata  = ow_wdata;
                s_alen   = ow_alen;
                m_aready = s_aready ? own_bit : 3'b000;
                if (ow_avalid && s_aready) begin
                    beat_d  = ow_we ? '0 : ow_alen;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (s_rvalid) begin
                    m_rvalid = own_bit;
                    m_rdata  = s_rdata;
                    if (beat_q == '0)
                        state_d = FIN;
                    else
                        beat_d = beat_q - 1'b1;
                end else if (tmo_exp) begin
                    m_rvalid = own_bit;
                    m_rerr   = 1'b1;
                    state_d  = FIN;
                end
            end
            FIN: begin
                finish  = own_bit;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Outputs are quiet for the whole reset cycle, whatever the state.
        if (rst) begin
            finish   = '0;
            m_aready = '0;
            m_rvalid = '0;
            m_rdata  = '0;
            m_rerr   = 1'b0;
            s_avalid = 1'b0;
            s_awe    = 1'b0;
            s_aaddr  = '0;
            s_wdata  = '0;
            s_alen   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            own_q   <= 2'd0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            beat_q  <= beat_d;
        end
    end

endmodule
